lsu_store_buffer: RTL and testbench

Store buffer and data-RAM port arbiter between the LSU execute stage and the single-port data RAM. It queues LSU stores so they retire without stalling the pipeline. It drains queued stores into the RAM on cycles when the LSU is not loading, and forwards buffered store data to younger loads. Load data is returned the following cycle, which is the cycle the LSU writeback stage samples `rd_data`.

---
 rtl/lsu_store_buffer.sv | 163 ++++++++++++++++
 tb/tb_lsu_store_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer
//   Store buffer and data-RAM port arbiter between LSU execute and a
//   single-port data RAM. Stores are queued in a circular FIFO and drained
//   on load-free cycles. Loads have priority on the RAM port and return
//   data one cycle after the request.
//
//   Optional feature macro: SB_FWD_EN
//     defined   : buffered store data is forwarded to younger loads.
//     undefined : no forwarding path. A load that hits a buffered word
//                 stalls until that word has drained to the RAM.
module lsu_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        sb_stall,
    output logic        sb_empty,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    input  logic [31:0] ram_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // FIFO state
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    // Load return pipeline
    logic          hit_q;
    logic          ld_q;
    logic [31:0]   fwd_q;

    // Combinational control
    logic          full;
    logic          empty;
    logic          hit;
    logic [31:0]   hit_data;
    logic [PW-1:0] idx;
    logic          fwd_stall;
    logic          load_req;
    logic          drain;
    logic          push;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Search valid entries oldest to youngest so the youngest word match wins
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit      = 1'b0;
        hit_data = '0;
        idx      = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < count) && (addr_mem[idx][31:2] == rd_addr[31:2])) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

`ifdef SB_FWD_EN
    // Hits are served from the buffer, so a load never waits on a drain.
    assign fwd_stall = 1'b0;
    assign load_req  = rd_en;
`else
    // Without forwarding a hitting load is held back and the drain runs,
    // so the matching stores reach the RAM before the load reads it.
    assign fwd_stall = rd_en && hit;
    assign load_req  = rd_en && !hit;
`endif

    // Loads own the RAM port; otherwise the head store drains
    assign drain = !load_req && !empty;

    // A stalled request is held by the LSU and re-presented, so a store
    // that arrives alongside a stalled load must not be taken twice.
    assign push  = wr_en && !full && !fwd_stall;

    // RAM port mux: load address, head entry, or idle zeros
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        if (load_req) begin
            ram_addr = rd_addr;
        end else if (drain) begin
            ram_addr  = addr_mem[head];
            ram_wdata = data_mem[head];
        end
    end

    // The read strobe is masked while reset is held; the write strobe is
    // already low then because the count is cleared.
    assign ram_re   = rst && load_req;
    assign ram_we   = drain;

    assign sb_stall = (wr_en && full) || fwd_stall;
    assign sb_empty = empty;

    // Entry storage: written at the tail on every accepted store
    always_ff @(posedge clk) begin
        // NOTE: the entry arrays have no reset; the count alone decides
        // which entries are valid, so stale contents are never observed.
        if (push) begin
            addr_mem[tail] <= wr_addr;
            data_mem[tail] <= wr_data;
        end
    end

    // Head, tail and count bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(drain);
        end
    end

    // Register the lookup result for the writeback-stage return
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q <= 1'b0;
            ld_q  <= 1'b0;
            fwd_q <= '0;
        end else begin
            ld_q  <= load_req;
`ifdef SB_FWD_EN
            hit_q <= rd_en && hit;
`else
            hit_q <= 1'b0;
`endif
            fwd_q <= (rd_en && hit) ? hit_data : '0;
        end
    end

    assign rd_data = ld_q ? (hit_q ? fwd_q : ram_rdata) : '0;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// tb_lsu_store_buffer
//   Directed bench for lsu_store_buffer (DEPTH = 4) with a behavioural RAM.
//   Expected RAM writes are queued when stores are accepted and compared as
//   the DUT drains them. Forwarding expectations follow SB_FWD_EN.
module tb_lsu_store_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        sb_stall;
    logic        sb_empty;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata = '0;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];

    logic [31:0] mem [logic [29:0]];

    lsu_store_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .sb_stall  (sb_stall),
        .sb_empty  (sb_empty),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] wkey(input logic [31:0] a);
        return a[31:2];
    endfunction

    // Synchronous single-port RAM: read data valid the cycle after ram_re
    always @(posedge clk) begin
        if (ram_we) begin
            mem[wkey(ram_addr)] = ram_wdata;
        end
        if (ram_re) begin
            ram_rdata <= mem.exists(wkey(ram_addr)) ? mem[wkey(ram_addr)] : 32'h0;
        end else begin
            ram_rdata <= 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic re, input logic [31:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
    endtask

    task automatic expect_write(input logic [31:0] wa, input logic [31:0] wd);
        exp_q.push_back('{addr: wa, data: wd});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Write scoreboard: every RAM write must match the oldest accepted store
    always @(negedge clk) begin
        #2;
        if (rst && ram_we) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", ram_addr, e.addr);
                check("wr_data", ram_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        mem[wkey(32'h0000_0300)] = 32'h0000_CAFE;
        mem[wkey(32'h0000_0800)] = 32'h5A5A_5A5A;

        // ---- reset state, with requests active ----
        tick();
        drive(1'b1, 32'h100, 32'h1111_1111, 1'b1, 32'h800);
        #1;
        check("rst_sb_empty", 32'(sb_empty), 32'd1);
        check("rst_rd_data",  rd_data,        32'h0);
        check("rst_ram_we",   32'(ram_we),   32'd0);
        check("rst_ram_re",   32'(ram_re),   32'd0);
        check("rst_sb_stall", 32'(sb_stall), 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();

        // ---- enqueue and drain ----
        drive(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0);
        #1;
        check("enq_stall", 32'(sb_stall), 32'd0);
        expect_write(32'h100, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        check("drain_we",    32'(ram_we),   32'd1);
        check("drain_addr",  ram_addr,       32'h100);
        check("drain_data",  ram_wdata,      32'hDEAD_BEEF);
        check("drain_empty", 32'(sb_empty), 32'd0);
        tick();
        #1;
        check("after_drain_empty", 32'(sb_empty), 32'd1);
        check("after_drain_we",    32'(ram_we),   32'd0);
        tick();

        // ---- fill to full while loads hold the RAM port ----
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h10 + 32'(i), 1'b1, 32'h800);
            #1;
            check("fill_stall",    32'(sb_stall), 32'd0);
            check("fill_no_drain", 32'(ram_we),   32'd0);
            if (i == 1) begin
                check("fill_load_ret", rd_data, 32'h5A5A_5A5A);
            end
            expect_write(32'h400 + 32'(4 * i), 32'h10 + 32'(i));
            tick();
        end
        drive(1'b1, 32'h410, 32'h14, 1'b1, 32'h800);
        #1;
        check("full_stall",  32'(sb_stall), 32'd1);
        check("full_ram_re", 32'(ram_re),   32'd1);
        tick();
        drive(1'b1, 32'h410, 32'h14, 1'b0, 32'h0);
        #1;
        check("full_drain_stall", 32'(sb_stall), 32'd1);
        check("full_drain_we",    32'(ram_we),   32'd1);
        check("full_drain_addr",  ram_addr,       32'h400);
        tick();
        #1;
        check("full_accept_stall", 32'(sb_stall), 32'd0);
        expect_write(32'h410, 32'h14);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (4) tick();
        #1;
        check("full_drained_empty", 32'(sb_empty), 32'd1);
        tick();

        // ---- youngest-match on the same word ----
        drive(1'b1, 32'h200, 32'h1, 1'b1, 32'h900);
        #1;
        expect_write(32'h200, 32'h1);
        tick();
        drive(1'b1, 32'h202, 32'h2, 1'b1, 32'h900);
        #1;
        expect_write(32'h202, 32'h2);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        #1;
`ifdef SB_FWD_EN
        check("yfwd_stall",    32'(sb_stall), 32'd0);
        check("yfwd_ram_re",   32'(ram_re),   32'd1);
        check("yfwd_ram_addr", ram_addr,       32'h200);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        check("yfwd_rd_data", rd_data, 32'h2);
        tick();
`else
        check("ynf_stall0",  32'(sb_stall), 32'd1);
        check("ynf_re0",     32'(ram_re),   32'd0);
        check("ynf_we0",     32'(ram_we),   32'd1);
        check("ynf_addr0",   ram_addr,       32'h200);
        tick();
        #1;
        check("ynf_stall1",  32'(sb_stall), 32'd1);
        check("ynf_we1",     32'(ram_we),   32'd1);
        check("ynf_addr1",   ram_addr,       32'h202);
        tick();
        #1;
        check("ynf_stall2",  32'(sb_stall), 32'd0);
        check("ynf_re2",     32'(ram_re),   32'd1);
        check("ynf_addr2",   ram_addr,       32'h200);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        check("ynf_rd_data", rd_data, 32'h2);
        tick();
`endif
        repeat (3) tick();
        #1;
        check("ymatch_empty", 32'(sb_empty), 32'd1);
        tick();

        // ---- load miss from an empty buffer ----
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h300);
        #1;
        check("miss_ram_re",   32'(ram_re), 32'd1);
        check("miss_ram_addr", ram_addr,     32'h300);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        check("miss_rd_data", rd_data, 32'h0000_CAFE);
        tick();
        #1;
        check("miss_rd_zero", rd_data, 32'h0);
        tick();

        // ---- reset with three stores queued ----
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA00 + 32'(4 * i), 32'h70 + 32'(i), 1'b1, 32'h900);
            #1;
            expect_write(32'hA00 + 32'(4 * i), 32'h70 + 32'(i));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h900);
        #1;
        check("pre_rst_count", 32'(sb_empty), 32'd0);
        tick();
        rst = 1'b1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_empty",   32'(sb_empty), 32'd1);
        check("mid_rst_ram_we",  32'(ram_we),   32'd0);
        check("mid_rst_ram_re",  32'(ram_re),   32'd0);
        check("mid_rst_rd_data", rd_data,        32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        #1;
        check("post_rst_empty", 32'(sb_empty), 32'd1);
        check("wr_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
